draw_gremlin: RTL

Pixel-pipeline stage that overlays the animated 16×32 gremlin sprite onto the VGA stream. It drives the gremlin sprite ROM address (frame select plus line index) and consumes the returned 16-bit pixel line. It also sequences the two-frame walk animation on frame boundaries. It sits in the video chain between the background/track drawer and the next overlay stage, and delays all timing signals to match its own latency.

---
 rtl/draw_gremlin.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/draw_gremlin.sv
// Overlays the animated 16x32 gremlin sprite on the video stream and sequences its two-frame walk.
// Latency: 2 pclk cycles for every timing/colour signal. No backpressure: one pixel per pclk.
// Frame toggles on vblank rising edges only, so rom_frame is stable during active video.
module draw_gremlin #(
    parameter logic [11:0] GREMLIN_COLOR   = 12'hF80,
    parameter int          FRAMES_PER_STEP = 8
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [10:0] xpos,
    input  logic [10:0] ypos,
    input  logic        visible,
    input  logic        anim_en,
    output logic        rom_frame,
    output logic [4:0]  rom_line,
    input  logic [15:0] rom_pixels,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out,
    output logic        gremlin_px
);

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } vid_t;

    typedef enum logic {
        FRAME0 = 1'b0,
        FRAME1 = 1'b1
    } anim_state_t;

    localparam logic [7:0] LAST_STEP = 8'(FRAMES_PER_STEP - 1);

    vid_t        s1_d, s1_q, out_d, out_q;
    logic        in_box_d, in_box_q;
    logic [4:0]  rom_line_d, rom_line_q;
    logic [3:0]  col_d, col_q;
    logic        gremlin_px_d, gremlin_px_q;
    anim_state_t state_d, state_q;
    logic [7:0]  step_cnt_d, step_cnt_q;
    logic        vblnk_prev_d, vblnk_prev_q;
    logic        vblnk_armed_d, vblnk_armed_q;

    logic [11:0] h_ext, v_ext, x_ext, y_ext;
    logic        pix_bit, blank_s1, set_px, tick;

    always_comb begin
        h_ext = {1'b0, hcount_in};
        v_ext = {1'b0, vcount_in};
        x_ext = {1'b0, xpos};
        y_ext = {1'b0, ypos};

        s1_d.hcount = hcount_in;
        s1_d.vcount = vcount_in;
        s1_d.hsync  = hsync_in;
        s1_d.vsync  = vsync_in;
        s1_d.hblnk  = hblnk_in;
        s1_d.vblnk  = vblnk_in;
        s1_d.rgb    = rgb_in;

        // 12-bit bounds so a sprite parked near 2047 cannot wrap onto column/row 0.
        in_box_d = visible
                 && (h_ext >= x_ext) && (h_ext < x_ext + 12'd16)
                 && (v_ext >= y_ext) && (v_ext < y_ext + 12'd32);

        rom_line_d = in_box_d ? (vcount_in[4:0] - ypos[4:0]) : rom_line_q;
        col_d      = hcount_in[3:0] - xpos[3:0];

        pix_bit  = rom_pixels[4'd15 - col_q];
        blank_s1 = s1_q.hblnk | s1_q.vblnk;
        set_px   = in_box_q & pix_bit & ~blank_s1;

        out_d = s1_q;
        if (set_px) begin
            out_d.rgb = GREMLIN_COLOR;
        end else if (blank_s1) begin
            out_d.rgb = 12'h000;
        end
        gremlin_px_d = set_px;

        // The armed flag keeps a vblank held high across reset release from counting as an edge.
        vblnk_prev_d  = vblnk_in;
        vblnk_armed_d = 1'b1;
        tick          = vblnk_in & ~vblnk_prev_q & vblnk_armed_q;

        state_d    = state_q;
        step_cnt_d = step_cnt_q;
        if (tick && anim_en) begin
            if (step_cnt_q == LAST_STEP) begin
                step_cnt_d = 8'd0;
                state_d    = (state_q == FRAME0) ? FRAME1 : FRAME0;
            end else begin
                step_cnt_d = step_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            s1_q          <= '0;
            out_q         <= '0;
            in_box_q      <= 1'b0;
            rom_line_q    <= 5'd0;
            col_q         <= 4'd0;
            gremlin_px_q  <= 1'b0;
            state_q       <= FRAME0;
            step_cnt_q    <= 8'd0;
            vblnk_prev_q  <= 1'b0;
            vblnk_armed_q <= 1'b0;
        end else begin
            s1_q          <= s1_d;
            out_q         <= out_d;
            in_box_q      <= in_box_d;
            rom_line_q    <= rom_line_d;
            col_q         <= col_d;
            gremlin_px_q  <= gremlin_px_d;
            state_q       <= state_d;
            step_cnt_q    <= step_cnt_d;
            vblnk_prev_q  <= vblnk_prev_d;
            vblnk_armed_q <= vblnk_armed_d;
        end
    end

    assign rom_frame  = (state_q == FRAME1);
    assign rom_line   = rom_line_q;
    assign hcount_out = out_q.hcount;
    assign vcount_out = out_q.vcount;
    assign hsync_out  = out_q.hsync;
    assign vsync_out  = out_q.vsync;
    assign hblnk_out  = out_q.hblnk;
    assign vblnk_out  = out_q.vblnk;
    assign rgb_out    = out_q.rgb;
    assign gremlin_px = gremlin_px_q;

endmodule
